// File: rtl/udma_l2_responder.sv
// L2 responder for the uDMA ro/wo memory ports: round-robin grant of one request
// per cycle into a single-port word memory, with a registered response one cycle later.
module udma_l2_responder #(
    parameter int unsigned L2_DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR     = 32'h1C00_0000,
    parameter logic [31:0] ERR_RDATA     = 32'hBADC_AB1E
) (
    input  logic                         sys_clk_i,
    input  logic                         sys_rst_i,

    input  logic                         L2_ro_req_i,
    output logic                         L2_ro_gnt_o,
    input  logic                         L2_ro_wen_i,
    input  logic [31:0]                  L2_ro_addr_i,
    input  logic [L2_DATA_WIDTH/8-1:0]   L2_ro_be_i,
    input  logic [L2_DATA_WIDTH-1:0]     L2_ro_wdata_i,
    output logic                         L2_ro_rvalid_o,
    output logic [L2_DATA_WIDTH-1:0]     L2_ro_rdata_o,

    input  logic                         L2_wo_req_i,
    output logic                         L2_wo_gnt_o,
    input  logic                         L2_wo_wen_i,
    input  logic [31:0]                  L2_wo_addr_i,
    input  logic [L2_DATA_WIDTH/8-1:0]   L2_wo_be_i,
    input  logic [L2_DATA_WIDTH-1:0]     L2_wo_wdata_i,
    output logic                         L2_wo_rvalid_o,
    output logic [L2_DATA_WIDTH-1:0]     L2_wo_rdata_o,

    output logic                         err_o
);

    localparam int unsigned BE_W       = L2_DATA_WIDTH / 8;
    localparam int unsigned OFF_W      = $clog2(BE_W);
    localparam int unsigned IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] SPAN_BYTES = 33'(MEM_WORDS) * 33'(BE_W);
    localparam int unsigned ERR_REPS   = (L2_DATA_WIDTH + 31) / 32;
    localparam logic [ERR_REPS*32-1:0]  ERR_REP  = {ERR_REPS{ERR_RDATA}};
    localparam logic [L2_DATA_WIDTH-1:0] ERR_WORD = ERR_REP[L2_DATA_WIDTH-1:0];

    logic                     rr_q;
    logic                     ro_gnt;
    logic                     wo_gnt;
    logic                     any_gnt;

    logic                     acc_wen_p0;
    logic [31:0]              acc_addr_p0;
    logic [BE_W-1:0]          acc_be_p0;
    logic [L2_DATA_WIDTH-1:0] acc_wdata_p0;
    logic [31:0]              acc_off_p0;
    logic                     acc_in_range_p0;
    logic [IDX_W-1:0]         acc_idx_p0;
    logic [L2_DATA_WIDTH-1:0] mem_rd_p0;
    logic [L2_DATA_WIDTH-1:0] wr_merge_p0;
    logic [L2_DATA_WIDTH-1:0] resp_data_p0;

    logic                     ro_vld_p1;
    logic                     wo_vld_p1;
    logic [L2_DATA_WIDTH-1:0] ro_rdata_p1;
    logic [L2_DATA_WIDTH-1:0] wo_rdata_p1;
    logic                     err_q;

    logic [L2_DATA_WIDTH-1:0] mem [MEM_WORDS];

    // rr_q names the port that wins the next contended cycle (0 = ro, 1 = wo)
    always_comb begin
        ro_gnt = 1'b0;
        wo_gnt = 1'b0;
        if (!sys_rst_i) begin
            ro_gnt = L2_ro_req_i && (!L2_wo_req_i || !rr_q);
            wo_gnt = L2_wo_req_i && (!L2_ro_req_i || rr_q);
        end
    end

    assign any_gnt = ro_gnt | wo_gnt;

    // Stage p0: granted request, address decode and memory read
    assign acc_wen_p0   = wo_gnt ? L2_wo_wen_i   : L2_ro_wen_i;
    assign acc_addr_p0  = wo_gnt ? L2_wo_addr_i  : L2_ro_addr_i;
    assign acc_be_p0    = wo_gnt ? L2_wo_be_i    : L2_ro_be_i;
    assign acc_wdata_p0 = wo_gnt ? L2_wo_wdata_i : L2_ro_wdata_i;

    // Addresses below BASE_ADDR wrap to huge offsets and fall out of range
    assign acc_off_p0      = acc_addr_p0 - BASE_ADDR;
    assign acc_in_range_p0 = {1'b0, acc_off_p0} < SPAN_BYTES;
    assign acc_idx_p0      = acc_off_p0[OFF_W +: IDX_W];
    assign mem_rd_p0       = mem[acc_idx_p0];

    for (genvar b = 0; b < BE_W; b++) begin : g_lane
        assign wr_merge_p0[8*b +: 8] = acc_be_p0[b] ? acc_wdata_p0[8*b +: 8]
                                                    : mem_rd_p0[8*b +: 8];
    end

    assign resp_data_p0 = !acc_wen_p0     ? '0 :
                          acc_in_range_p0 ? mem_rd_p0 : ERR_WORD;

    // Memory write is deliberately not gated by reset
    always_ff @(posedge sys_clk_i) begin
        if (any_gnt && !acc_wen_p0 && acc_in_range_p0) begin
            mem[acc_idx_p0] <= wr_merge_p0;
        end
    end

    // Stage p1: registered responses, sticky error and arbiter pointer
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            ro_vld_p1   <= 1'b0;
            wo_vld_p1   <= 1'b0;
            ro_rdata_p1 <= '0;
            wo_rdata_p1 <= '0;
            err_q       <= 1'b0;
            rr_q        <= 1'b0;
        end else begin
            ro_vld_p1 <= ro_gnt;
            wo_vld_p1 <= wo_gnt;
            if (ro_gnt) begin
                ro_rdata_p1 <= resp_data_p0;
            end
            if (wo_gnt) begin
                wo_rdata_p1 <= resp_data_p0;
            end
            if (any_gnt && !acc_in_range_p0) begin
                err_q <= 1'b1;
            end
            if (L2_ro_req_i && L2_wo_req_i) begin
                rr_q <= ~rr_q;
            end
        end
    end

    // A response due while reset is held is suppressed, matching the forced-low grants
    assign L2_ro_gnt_o    = ro_gnt;
    assign L2_wo_gnt_o    = wo_gnt;
    assign L2_ro_rvalid_o = ro_vld_p1 & ~sys_rst_i;
    assign L2_wo_rvalid_o = wo_vld_p1 & ~sys_rst_i;
    assign L2_ro_rdata_o  = ro_rdata_p1;
    assign L2_wo_rdata_o  = wo_rdata_p1;
    assign err_o          = err_q;

endmodule

// File: tb/tb_udma_l2_responder.sv
// Bench for udma_l2_responder: directed scenarios plus randomized traffic, all
// checked against a word-array memory model with spec-level arbitration rules.
module tb_udma_l2_responder;

    localparam logic [31:0] BASE  = 32'h1C00_0000;
    localparam int          WORDS = 1024;
    localparam logic [31:0] SPAN  = 32'd4096;
    localparam logic [31:0] ERRV  = 32'hBADC_AB1E;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, wen, gnt, rv;
    logic [31:0] addr [2];
    logic [31:0] wd   [2];
    logic [31:0] rd   [2];
    logic [3:0]  be   [2];
    logic        err;

    always #5 clk = ~clk;

    udma_l2_responder dut (
        .sys_clk_i      (clk),
        .sys_rst_i      (rst),
        .L2_ro_req_i    (req[0]),
        .L2_ro_gnt_o    (gnt[0]),
        .L2_ro_wen_i    (wen[0]),
        .L2_ro_addr_i   (addr[0]),
        .L2_ro_be_i     (be[0]),
        .L2_ro_wdata_i  (wd[0]),
        .L2_ro_rvalid_o (rv[0]),
        .L2_ro_rdata_o  (rd[0]),
        .L2_wo_req_i    (req[1]),
        .L2_wo_gnt_o    (gnt[1]),
        .L2_wo_wen_i    (wen[1]),
        .L2_wo_addr_i   (addr[1]),
        .L2_wo_be_i     (be[1]),
        .L2_wo_wdata_i  (wd[1]),
        .L2_wo_rvalid_o (rv[1]),
        .L2_wo_rdata_o  (rd[1]),
        .err_o          (err)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] mem_m [WORDS];
    logic        err_m   = 1'b0;
    int          pref    = 0;
    logic [1:0]  exp_v   = 2'b00;
    logic [31:0] exp_d [2];
    bit          chk_on  = 1'b0;
    int          last_win;
    int          gq[$];
    int          n_rv [2];

    bit          pr [2];
    logic        pw [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    logic [3:0]  pb [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        req[p]  = r;
        wen[p]  = w;
        addr[p] = a;
        be[p]   = b;
        wd[p]   = d;
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom % 20);
        if (r == 0) return BASE + SPAN + ($urandom % 256);
        if (r == 1) return BASE - 32'd1 - ($urandom % 64);
        return BASE + ($urandom % 4096);
    endfunction

    // One cycle: inputs already driven at the falling edge; observe, model, advance
    task automatic tick();
        int          win;
        logic [31:0] off;
        int          idx;
        logic        inr;
        #1;
        if (rv[0] === 1'b1) n_rv[0]++;
        if (rv[1] === 1'b1) n_rv[1]++;
        if (chk_on) begin
            chk("ro_rvalid", 32'(rv[0]), 32'(exp_v[0] & ~rst));
            chk("wo_rvalid", 32'(rv[1]), 32'(exp_v[1] & ~rst));
            if (exp_v[0] && !rst) chk("ro_rdata", rd[0], exp_d[0]);
            if (exp_v[1] && !rst) chk("wo_rdata", rd[1], exp_d[1]);
            chk("err", 32'(err), 32'(err_m));
        end
        win = -1;
        if (!rst) begin
            if (req[0] && req[1]) begin
                win  = pref;
                pref = 1 - pref;
            end else if (req[0]) begin
                win = 0;
            end else if (req[1]) begin
                win = 1;
            end
        end
        if (chk_on) begin
            chk("ro_gnt", 32'(gnt[0]), 32'(win == 0));
            chk("wo_gnt", 32'(gnt[1]), 32'(win == 1));
        end
        exp_v = 2'b00;
        if (win >= 0) begin
            gq.push_back(win);
            off = addr[win] - BASE;
            inr = off < SPAN;
            idx = int'(off >> 2);
            exp_v[win] = 1'b1;
            if (wen[win]) begin
                exp_d[win] = inr ? mem_m[idx] : ERRV;
            end else begin
                exp_d[win] = 32'h0;
                if (inr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[win][b]) mem_m[idx][8*b +: 8] = wd[win][8*b +: 8];
                    end
                end
            end
            if (!inr) err_m = 1'b1;
        end
        if (rst) begin
            err_m = 1'b0;
            pref  = 0;
        end
        last_win = win;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        exp_d[0] = 32'h0;
        exp_d[1] = 32'h0;
        n_rv[0] = 0;
        n_rv[1] = 0;
        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ro_rvalid", 32'(rv[0]), 32'h0);
        chk("rst_wo_rvalid", 32'(rv[1]), 32'h0);
        chk("rst_ro_rdata", rd[0], 32'h0);
        chk("rst_wo_rdata", rd[1], 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // Fill every word so the model knows the whole memory
        for (int i = 0; i < WORDS; i++) begin
            drive(0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
            drive(1, 1'b1, 1'b0, BASE + 32'(4 * i), 4'hF, $urandom);
            tick();
        end
        idle();
        tick();

        drive(1, 1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'hDEAD_BEEF);
        tick();
        chk("wr_rvalid", 32'(rv[1]), 32'h1);
        chk("wr_rdata", rd[1], 32'h0);
        drive(1, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        drive(0, 1'b1, 1'b1, BASE + 32'd8, 4'h0, 32'h0);
        tick();
        chk("rd_rvalid", 32'(rv[0]), 32'h1);
        chk("rd_data", rd[0], 32'hDEAD_BEEF);

        drive(0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b1, 1'b0, BASE + 32'd16, 4'hF, 32'h1122_3344);
        tick();
        drive(1, 1'b1, 1'b0, BASE + 32'd16, 4'b0101, 32'hAABB_CCDD);
        tick();
        drive(1, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        drive(0, 1'b1, 1'b1, BASE + 32'd16, 4'h0, 32'h0);
        tick();
        chk("be_data", rd[0], 32'h11BB_33DD);

        drive(0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b1, 1'b0, BASE + 32'd4, 4'hF, 32'hCAFE_0123);
        tick();
        drive(1, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        drive(0, 1'b1, 1'b1, BASE + 32'd7, 4'h0, 32'h0);
        tick();
        chk("misalign", rd[0], 32'hCAFE_0123);

        // Contention straight out of reset
        rst = 1'b1;
        drive(0, 1'b1, 1'b1, BASE + 32'd8, 4'h0, 32'h0);
        drive(1, 1'b1, 1'b1, BASE + 32'd16, 4'h0, 32'h0);
        tick();
        rst = 1'b0;
        chk("rst2_ro_rdata", rd[0], 32'h0);
        gq.delete();
        n_rv[0] = 0;
        n_rv[1] = 0;
        repeat (6) tick();
        idle();
        tick();
        chk("rr_cnt", 32'(gq.size()), 32'd6);
        foreach (gq[i]) chk($sformatf("rr_order%0d", i), 32'(gq[i]), 32'(i % 2));
        chk("rr_rv_ro", 32'(n_rv[0]), 32'd3);
        chk("rr_rv_wo", 32'(n_rv[1]), 32'd3);

        chk("pre_err", 32'(err), 32'h0);
        drive(0, 1'b1, 1'b1, BASE + SPAN, 4'h0, 32'h0);
        tick();
        drive(0, 1'b1, 1'b1, BASE - 32'd4, 4'h0, 32'h0);
        tick();
        chk("oor_hi", rd[0], ERRV);
        chk("oor_err", 32'(err), 32'h1);
        idle();
        tick();
        chk("oor_lo", rd[0], ERRV);
        drive(1, 1'b1, 1'b0, BASE + SPAN, 4'hF, $urandom);
        tick();
        idle();
        tick();
        chk("oor_err_sticky", 32'(err), 32'h1);

        // Reset the cycle after a read grant; a write before it must still land
        drive(1, 1'b1, 1'b0, BASE + 32'd40, 4'hF, 32'h5A5A_1234);
        tick();
        drive(1, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        drive(0, 1'b1, 1'b1, BASE + 32'd8, 4'h0, 32'h0);
        tick();
        rst = 1'b1;
        drive(1, 1'b1, 1'b1, BASE + 32'd16, 4'h0, 32'h0);
        #1;
        chk("rst_no_rvalid", 32'(rv[0]), 32'h0);
        chk("rst_gnt_ro", 32'(gnt[0]), 32'h0);
        chk("rst_gnt_wo", 32'(gnt[1]), 32'h0);
        tick();
        rst = 1'b0;
        chk("rst_err_clr", 32'(err), 32'h0);
        #1;
        chk("rst_rr_ro", 32'(gnt[0]), 32'h1);
        tick();
        drive(0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        tick();
        drive(1, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        drive(0, 1'b1, 1'b1, BASE + 32'd40, 4'h0, 32'h0);
        tick();
        chk("rst_wr_landed", rd[0], 32'h5A5A_1234);

        // Random traffic; masters hold a request until granted
        pr[0] = 1'b0;
        pr[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pr[p] && ($urandom % 4 != 0)) begin
                    pr[p] = 1'b1;
                    pw[p] = 1'($urandom % 2);
                    pa[p] = rand_addr();
                    pb[p] = 4'($urandom);
                    pd[p] = $urandom;
                end
                drive(p, pr[p], pw[p], pa[p], pb[p], pd[p]);
            end
            rst = ($urandom % 250 == 0);
            tick();
            if (last_win >= 0) pr[last_win] = 1'b0;
        end
        rst = 1'b0;

        // Read back every word
        idle();
        tick();
        for (int i = 0; i < WORDS; i++) begin
            drive(0, 1'b1, 1'b1, BASE + 32'(4 * i), 4'h0, 32'h0);
            tick();
        end
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
